// File: rtl/ads5404_sync_align.sv
// ads5404_sync_align
// Purpose: aligns the ADS5404 two-samples-per-clock stream to the SYNC phase.
//   The block locks the sample-pair phase to the first SYNC edge and realigns
//   channels A and B so that output sample 0 is always the SYNC-aligned sample.
//   It can convert offset-binary to two's complement and measures the SYNC
//   period. It flags SYNC phase and period errors and keeps saturating
//   overrange counters.
// Ports:
//   clk, nrst                   clkout-domain clock, synchronous active-low reset
//   da_0/da_1, db_0/db_1        input sample pairs (x_0 is earlier in time)
//   sync_0/sync_1               syncout flag per sample
//   ovra_0/1, ovrb_0/1          overrange flags per sample
//   realign                     drops lock; relocks on the next SYNC edge
//   cnt_clr                     clears overrange counters and sync_err
//   a_0/a_1, b_0/b_1            aligned output pairs
//   sync_out                    marks the pair whose sample 0 is the SYNC edge
//   locked, sync_phase          lock status and locked phase
//   sync_period                 clk cycles between the last two SYNC edges
//   sync_err                    sticky phase or period error
//   ovra_cnt, ovrb_cnt          saturating overrange counts
module ads5404_sync_align #(
  parameter int NBITS     = 12,
  parameter int TWOS_COMP = 1,
  parameter int CNT_BITS  = 16
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic [NBITS-1:0]    da_0,
  input  logic [NBITS-1:0]    da_1,
  input  logic [NBITS-1:0]    db_0,
  input  logic [NBITS-1:0]    db_1,
  input  logic                sync_0,
  input  logic                sync_1,
  input  logic                ovra_0,
  input  logic                ovra_1,
  input  logic                ovrb_0,
  input  logic                ovrb_1,
  input  logic                realign,
  input  logic                cnt_clr,
  output logic [NBITS-1:0]    a_0,
  output logic [NBITS-1:0]    a_1,
  output logic [NBITS-1:0]    b_0,
  output logic [NBITS-1:0]    b_1,
  output logic                sync_out,
  output logic                locked,
  output logic                sync_phase,
  output logic [31:0]         sync_period,
  output logic                sync_err,
  output logic [CNT_BITS-1:0] ovra_cnt,
  output logic [CNT_BITS-1:0] ovrb_cnt
);

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_t;

  localparam logic                MSB_FLIP = (TWOS_COMP != 0);
  localparam logic [NBITS-1:0]    MSB_MASK = {MSB_FLIP, {(NBITS-1){1'b0}}};
  localparam logic [31:0]         PER_MAX  = '1;
  localparam logic [CNT_BITS-1:0] OVR_MAX  = '1;

  state_t           r_state;
  logic             r_prev_s1;
  logic [NBITS-1:0] r_p1_a0, r_p1_a1, r_p1_b0, r_p1_b1;
  logic [NBITS-1:0] r_p2_a1, r_p2_b1;
  logic             r_acc0_p1, r_acc1_p1, r_acc1_p2;
  logic [31:0]      r_cnt;
  logic             r_first_seen;
  logic             r_per_valid;

  logic             w_edge0, w_edge1, w_edge;
  logic             w_acc0, w_acc1;
  logic             w_phase_err, w_per_err;
  logic [31:0]      w_cnt_inc;
  logic [NBITS-1:0] w_a0, w_a1, w_b0, w_b1;

  // Serial rising edge of SYNC: sample 0 looks back at last cycle's sample 1.
  assign w_edge0 = sync_0 & ~r_prev_s1;
  assign w_edge1 = sync_1 & ~sync_0;
  // realign wins over a coincident edge, so the edge is dropped entirely.
  assign w_edge  = (w_edge0 | w_edge1) & ~realign;

  // An edge is "accepted" (eligible for sync_out) if it locks or matches the lock.
  assign w_acc0 = w_edge0 & ~realign & (~locked | ~sync_phase);
  assign w_acc1 = w_edge1 & ~realign & (~locked | sync_phase);

  assign w_phase_err = w_edge & locked & (w_edge1 != sync_phase);
  assign w_cnt_inc   = (r_cnt == PER_MAX) ? PER_MAX : (r_cnt + 32'd1);
  // Mismatch is only meaningful once a period has been held (third edge on).
  assign w_per_err   = w_edge & r_first_seen & r_per_valid & (w_cnt_inc != sync_period);

  // Phase-lock state machine with registered lock status and phase.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state    <= ST_UNLOCKED;
      locked     <= 1'b0;
      sync_phase <= 1'b0;
    end else begin
      case (r_state)
        ST_UNLOCKED: begin
          if (realign) begin
            r_state    <= ST_UNLOCKED;
            locked     <= 1'b0;
            sync_phase <= 1'b0;
          end else if (w_edge0 || w_edge1) begin
            r_state    <= ST_LOCKED;
            locked     <= 1'b1;
            sync_phase <= w_edge1;
          end else begin
            r_state    <= ST_UNLOCKED;
          end
        end
        ST_LOCKED: begin
          if (realign) begin
            r_state    <= ST_UNLOCKED;
            locked     <= 1'b0;
            sync_phase <= 1'b0;
          end else begin
            r_state    <= ST_LOCKED;
          end
        end
        default: begin
          r_state    <= ST_UNLOCKED;
          locked     <= 1'b0;
          sync_phase <= 1'b0;
        end
      endcase
    end
  end

  // Input pipeline for data and for accepted-edge markers.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_prev_s1 <= 1'b0;
      r_p1_a0   <= '0;
      r_p1_a1   <= '0;
      r_p1_b0   <= '0;
      r_p1_b1   <= '0;
      r_p2_a1   <= '0;
      r_p2_b1   <= '0;
      r_acc0_p1 <= 1'b0;
      r_acc1_p1 <= 1'b0;
      r_acc1_p2 <= 1'b0;
    end else begin
      r_prev_s1 <= sync_1;
      r_p1_a0   <= da_0;
      r_p1_a1   <= da_1;
      r_p1_b0   <= db_0;
      r_p1_b1   <= db_1;
      r_p2_a1   <= r_p1_a1;
      r_p2_b1   <= r_p1_b1;
      r_acc0_p1 <= w_acc0;
      r_acc1_p1 <= w_acc1;
      r_acc1_p2 <= r_acc1_p1;
    end
  end

  // Phase mux: phase 1 pairs last cycle's sample 1 with this cycle's sample 0.
  always_comb begin
    w_a0 = r_p1_a0;
    w_a1 = r_p1_a1;
    w_b0 = r_p1_b0;
    w_b1 = r_p1_b1;
    if (sync_phase) begin
      w_a0 = r_p2_a1;
      w_a1 = r_p1_a0;
      w_b0 = r_p2_b1;
      w_b1 = r_p1_b0;
    end else begin
      w_a0 = r_p1_a0;
      w_a1 = r_p1_a1;
      w_b0 = r_p1_b0;
      w_b1 = r_p1_b1;
    end
  end

  // Output register with optional MSB flip; sync_out follows the same phase.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      a_0      <= '0;
      a_1      <= '0;
      b_0      <= '0;
      b_1      <= '0;
      sync_out <= 1'b0;
    end else begin
      a_0      <= w_a0 ^ MSB_MASK;
      a_1      <= w_a1 ^ MSB_MASK;
      b_0      <= w_b0 ^ MSB_MASK;
      b_1      <= w_b1 ^ MSB_MASK;
      sync_out <= locked & (sync_phase ? r_acc1_p2 : r_acc0_p1);
    end
  end

  // SYNC period measurement; the first edge after reset/realign only starts the count.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_cnt        <= 32'd0;
      r_first_seen <= 1'b0;
      r_per_valid  <= 1'b0;
      sync_period  <= 32'd0;
    end else if (realign) begin
      r_cnt        <= w_cnt_inc;
      r_first_seen <= 1'b0;
      r_per_valid  <= 1'b0;
    end else if (w_edge) begin
      r_cnt        <= 32'd0;
      r_first_seen <= 1'b1;
      if (r_first_seen) begin
        sync_period <= w_cnt_inc;
        r_per_valid <= 1'b1;
      end else begin
        sync_period <= sync_period;
      end
    end else begin
      r_cnt        <= w_cnt_inc;
    end
  end

  // Sticky error flag; cnt_clr beats a same-cycle error.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      sync_err <= 1'b0;
    end else if (cnt_clr) begin
      sync_err <= 1'b0;
    end else if (w_phase_err || w_per_err) begin
      sync_err <= 1'b1;
    end else begin
      sync_err <= sync_err;
    end
  end

  // Saturating overrange counters; cnt_clr beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      ovra_cnt <= '0;
      ovrb_cnt <= '0;
    end else if (cnt_clr) begin
      ovra_cnt <= '0;
      ovrb_cnt <= '0;
    end else begin
      if ((ovra_0 || ovra_1) && (ovra_cnt != OVR_MAX)) begin
        ovra_cnt <= ovra_cnt + CNT_BITS'(1);
      end else begin
        ovra_cnt <= ovra_cnt;
      end
      if ((ovrb_0 || ovrb_1) && (ovrb_cnt != OVR_MAX)) begin
        ovrb_cnt <= ovrb_cnt + CNT_BITS'(1);
      end else begin
        ovrb_cnt <= ovrb_cnt;
      end
    end
  end

endmodule

// File: tb/tb_ads5404_sync_align.sv
// Self-checking bench for ads5404_sync_align: reset, overrange table, directed
// lock/period/realign sequences and a randomized run against a serial-stream model.
module tb_ads5404_sync_align;
  localparam int NBITS     = 12;
  localparam int CNT_BITS  = 16;
  localparam int TWOS_COMP = 1;
  localparam int NRAND     = 3000;
  localparam logic [NBITS-1:0] MSB = {1'b1, {(NBITS-1){1'b0}}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic nrst;
  logic [NBITS-1:0] da_0, da_1, db_0, db_1;
  logic sync_0, sync_1, ovra_0, ovra_1, ovrb_0, ovrb_1, realign, cnt_clr;
  logic [NBITS-1:0] a_0, a_1, b_0, b_1;
  logic sync_out, locked, sync_phase, sync_err;
  logic [31:0] sync_period;
  logic [CNT_BITS-1:0] ovra_cnt, ovrb_cnt;

  ads5404_sync_align #(.NBITS(NBITS), .TWOS_COMP(TWOS_COMP), .CNT_BITS(CNT_BITS)) dut (
    .clk(clk), .nrst(nrst),
    .da_0(da_0), .da_1(da_1), .db_0(db_0), .db_1(db_1),
    .sync_0(sync_0), .sync_1(sync_1),
    .ovra_0(ovra_0), .ovra_1(ovra_1), .ovrb_0(ovrb_0), .ovrb_1(ovrb_1),
    .realign(realign), .cnt_clr(cnt_clr),
    .a_0(a_0), .a_1(a_1), .b_0(b_0), .b_1(b_1),
    .sync_out(sync_out), .locked(locked), .sync_phase(sync_phase),
    .sync_period(sync_period), .sync_err(sync_err),
    .ovra_cnt(ovra_cnt), .ovrb_cnt(ovrb_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    da_0 = '0; da_1 = '0; db_0 = '0; db_1 = '0;
    sync_0 = 1'b0; sync_1 = 1'b0;
    ovra_0 = 1'b0; ovra_1 = 1'b0; ovrb_0 = 1'b0; ovrb_1 = 1'b0;
    realign = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    idle_inputs();
    step();
    step();
    nrst = 1'b1;
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic sync_pulse(input bit ph);
    sync_0 = ~ph;
    sync_1 = ph;
    step();
    sync_0 = 1'b0;
    sync_1 = 1'b0;
  endtask

  // Ramp: da_0=2n, da_1=2n+1, B channel offset by 256; one SYNC edge at cycle edge_c.
  task automatic ramp_run(input int edge_c, input bit ph, output int pulses, output int at,
                          output logic [NBITS-1:0] ra0, output logic [NBITS-1:0] ra1,
                          output logic [NBITS-1:0] rb0, output logic [NBITS-1:0] rb1);
    pulses = 0; at = -1; ra0 = '0; ra1 = '0; rb0 = '0; rb1 = '0;
    for (int n = 0; n < 26; n++) begin
      da_0 = NBITS'(2*n);       da_1 = NBITS'(2*n + 1);
      db_0 = NBITS'(2*n + 256); db_1 = NBITS'(2*n + 257);
      sync_0 = (n == edge_c) && !ph;
      sync_1 = (n == edge_c) && ph;
      step();
      if (sync_out) begin
        pulses++; at = n; ra0 = a_0; ra1 = a_1; rb0 = b_0; rb1 = b_1;
      end
    end
    idle_inputs();
  endtask

  typedef struct packed {
    logic oa0, oa1, ob0, ob1, clr;
    logic [CNT_BITS-1:0] ea, eb;
  } ovr_vec_t;
  ovr_vec_t tbl [9];

  // Reference model: serial sample/sync streams (index 2*cycle + k).
  logic [NBITS-1:0] sa [0:2*NRAND-1];
  logic [NBITS-1:0] sb [0:2*NRAND-1];
  bit               ss [0:2*NRAND-1];
  bit               acc[0:2*NRAND-1];
  bit               lh [0:NRAND-1];
  bit               phh[0:NRAND-1];

  function automatic logic [NBITS-1:0] get_sa(input int i);
    return (i < 0) ? '0 : sa[i];
  endfunction
  function automatic logic [NBITS-1:0] get_sb(input int i);
    return (i < 0) ? '0 : sb[i];
  endfunction
  function automatic bit get_ss(input int i);
    return (i < 0) ? 1'b0 : ss[i];
  endfunction
  function automatic bit get_acc(input int i);
    return (i < 0) ? 1'b0 : acc[i];
  endfunction

  initial begin
    int pulses, at;
    logic [NBITS-1:0] ra0, ra1, rb0, rb1, pa0, pa1;
    bit m_locked, m_phase, m_err, ev_err, edge_seen;
    int m_last, m_nedges, edge_idx, newp, base, phe, m_ova, m_ovb;
    logic [31:0] m_period;

    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 16'd0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd2, 16'd1};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'd3, 16'd2};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd3, 16'd2};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd3, 16'd3};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'd0, 16'd0};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 16'd1};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1, 16'd1};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 16'd0};

    // ---- Reset with random inputs ----
    nrst = 1'b0;
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      da_0 = NBITS'($urandom()); da_1 = NBITS'($urandom());
      db_0 = NBITS'($urandom()); db_1 = NBITS'($urandom());
      sync_0 = 1'($urandom()); sync_1 = 1'($urandom());
      ovra_0 = 1'($urandom()); ovrb_1 = 1'($urandom());
      realign = 1'($urandom()); cnt_clr = 1'($urandom());
      step();
    end
    check("rst_a0", a_0, 0);  check("rst_a1", a_1, 0);
    check("rst_b0", b_0, 0);  check("rst_b1", b_1, 0);
    check("rst_sync_out", sync_out, 0); check("rst_locked", locked, 0);
    check("rst_phase", sync_phase, 0);  check("rst_period", sync_period, 0);
    check("rst_err", sync_err, 0);
    check("rst_ovra", ovra_cnt, 0);     check("rst_ovrb", ovrb_cnt, 0);

    nrst = 1'b1;
    idle_inputs();
    pa0 = '0; pa1 = '0;
    for (int i = 0; i < 6; i++) begin
      da_0 = NBITS'($urandom()); da_1 = NBITS'($urandom());
      step();
      check("post_rst_a0", a_0, pa0 ^ MSB);
      check("post_rst_a1", a_1, pa1 ^ MSB);
      check("post_rst_locked", locked, 0);
      pa0 = da_0; pa1 = da_1;
    end

    // ---- Overrange table ----
    do_reset();
    for (int i = 0; i < 9; i++) begin
      ovra_0 = tbl[i].oa0; ovra_1 = tbl[i].oa1;
      ovrb_0 = tbl[i].ob0; ovrb_1 = tbl[i].ob1;
      cnt_clr = tbl[i].clr;
      step();
      check("tbl_ovra", ovra_cnt, tbl[i].ea);
      check("tbl_ovrb", ovrb_cnt, tbl[i].eb);
    end
    idle_inputs();
    ovrb_1 = 1'b1;
    idle_n(5);
    ovrb_1 = 1'b0;
    check("ovrb_5", ovrb_cnt, 5);
    ovra_0 = 1'b1;
    idle_n(65534);
    check("ovra_65534", ovra_cnt, 65534);
    idle_n(4466);
    check("ovra_sat", ovra_cnt, 65535);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check("ovra_clr_prio", ovra_cnt, 0);
    step();
    check("ovra_after_clr", ovra_cnt, 1);
    idle_inputs();

    // ---- Phase-0 lock ----
    do_reset();
    ramp_run(10, 1'b0, pulses, at, ra0, ra1, rb0, rb1);
    check("ph0_locked", locked, 1);       check("ph0_phase", sync_phase, 0);
    check("ph0_pulses", pulses, 1);       check("ph0_at", at, 11);
    check("ph0_a0", ra0, 12'd20 ^ MSB);   check("ph0_a1", ra1, 12'd21 ^ MSB);
    check("ph0_b0", rb0, 12'd276 ^ MSB);  check("ph0_b1", rb1, 12'd277 ^ MSB);

    // ---- Phase-1 lock ----
    do_reset();
    ramp_run(10, 1'b1, pulses, at, ra0, ra1, rb0, rb1);
    check("ph1_locked", locked, 1);       check("ph1_phase", sync_phase, 1);
    check("ph1_pulses", pulses, 1);       check("ph1_at", at, 12);
    check("ph1_a0", ra0, 12'd21 ^ MSB);   check("ph1_a1", ra1, 12'd22 ^ MSB);
    check("ph1_b0", rb0, 12'd277 ^ MSB);  check("ph1_b1", rb1, 12'd278 ^ MSB);

    // ---- Period and period error ----
    do_reset();
    idle_n(3);
    sync_pulse(1'b0);
    check("per_first_locked", locked, 1);
    check("per_first_nothing", sync_period, 0);
    for (int k = 0; k < 3; k++) begin
      idle_n(63);
      sync_pulse(1'b0);
      check("per_64", sync_period, 64);
      check("per_err0", sync_err, 0);
    end
    idle_n(62);
    sync_pulse(1'b0);
    check("per_63", sync_period, 63);
    check("per_err1", sync_err, 1);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check("per_err_clr", sync_err, 0);

    // ---- Phase error and realign ----
    do_reset();
    idle_n(2);
    sync_pulse(1'b0);
    idle_n(5);
    sync_pulse(1'b1);
    check("pe_err", sync_err, 1);
    check("pe_phase_kept", sync_phase, 0);
    check("pe_still_locked", locked, 1);
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    realign = 1'b1; step(); realign = 1'b0;
    check("ra_unlocked", locked, 0);
    idle_n(3);
    sync_pulse(1'b1);
    check("ra_relocked", locked, 1);
    check("ra_phase1", sync_phase, 1);
    check("ra_no_err", sync_err, 0);
    realign = 1'b1; sync_0 = 1'b1; step(); realign = 1'b0; sync_0 = 1'b0;
    check("ra_edge_ignored", locked, 0);
    idle_n(3);
    sync_pulse(1'b0);
    check("ra_relock0", locked, 1);
    check("ra_relock0_phase", sync_phase, 0);

    // ---- Randomized run vs. serial-stream model ----
    do_reset();
    m_locked = 0; m_phase = 0; m_err = 0; m_last = 0; m_nedges = 0;
    m_period = 32'd0; m_ova = 0; m_ovb = 0;
    for (int c = 0; c < NRAND; c++) begin
      da_0 = NBITS'($urandom()); da_1 = NBITS'($urandom());
      db_0 = NBITS'($urandom()); db_1 = NBITS'($urandom());
      sync_0 = ($urandom_range(0, 9) == 0);
      sync_1 = ($urandom_range(0, 9) == 0);
      ovra_0 = ($urandom_range(0, 3) == 0); ovra_1 = ($urandom_range(0, 3) == 0);
      ovrb_0 = ($urandom_range(0, 3) == 0); ovrb_1 = ($urandom_range(0, 3) == 0);
      realign = ($urandom_range(0, 63) == 0);
      cnt_clr = ($urandom_range(0, 63) == 0);

      sa[2*c] = da_0; sa[2*c+1] = da_1;
      sb[2*c] = db_0; sb[2*c+1] = db_1;
      ss[2*c] = sync_0; ss[2*c+1] = sync_1;
      acc[2*c] = 1'b0; acc[2*c+1] = 1'b0;
      edge_seen = 0; edge_idx = 0; ev_err = 0;
      for (int k = 0; k < 2; k++) begin
        if (get_ss(2*c+k) && !get_ss(2*c+k-1)) begin
          edge_seen = 1; edge_idx = 2*c + k;
        end
      end
      if (realign) begin
        m_locked = 0; m_phase = 0; m_nedges = 0;
      end else if (edge_seen) begin
        if (!m_locked) begin
          m_locked = 1; m_phase = edge_idx[0]; acc[edge_idx] = 1'b1;
        end else if (edge_idx[0] == m_phase) begin
          acc[edge_idx] = 1'b1;
        end else begin
          ev_err = 1;
        end
        if (m_nedges >= 1) begin
          newp = c - m_last;
          if (m_nedges >= 2 && newp != int'(m_period)) ev_err = 1;
          m_period = 32'(newp);
        end
        m_last = c;
        if (m_nedges < 2) m_nedges++;
      end
      if (cnt_clr) begin
        m_err = 0; m_ova = 0; m_ovb = 0;
      end else begin
        if (ev_err) m_err = 1;
        if ((ovra_0 || ovra_1) && m_ova < 65535) m_ova++;
        if ((ovrb_0 || ovrb_1) && m_ovb < 65535) m_ovb++;
      end
      lh[c] = m_locked; phh[c] = m_phase;

      step();

      check("rnd_locked", locked, m_locked);
      if (m_locked) check("rnd_phase", sync_phase, m_phase);
      check("rnd_period", sync_period, m_period);
      check("rnd_err", sync_err, m_err);
      check("rnd_ovra", ovra_cnt, m_ova);
      check("rnd_ovrb", ovrb_cnt, m_ovb);
      phe  = (c >= 1 && lh[c-1]) ? int'(phh[c-1]) : 0;
      base = 2*(c-1) - phe;
      check("rnd_a0", a_0, get_sa(base) ^ MSB);
      check("rnd_a1", a_1, get_sa(base+1) ^ MSB);
      check("rnd_b0", b_0, get_sb(base) ^ MSB);
      check("rnd_b1", b_1, get_sb(base+1) ^ MSB);
      check("rnd_sync_out", sync_out, (c >= 1) && lh[c-1] && get_acc(base));
    end
    idle_inputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
